// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches one-cycle request strobes into fixed-length level pulses with an enforced low gap
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int RETRIGGER   = 0,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic p,
  output logic z,
  output logic busy,
  output logic drop
);
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;
  localparam logic [CNT_W-1:0] HI = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GP = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, drop_q, drop_d, z_q, z_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (p) begin
          state_d = HOLD;
          cnt_d   = HI;
        end
      end
      HOLD: begin
        if (RETRIGGER != 0 && p) cnt_d = HI;
        else begin
          // a strobe while a request is already queued is the one discarded
          if (p) begin
            pend_d = 1'b1;
            drop_d = pend_q;
          end
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GP;
          end else if (pend_q || p) begin
            cnt_d  = HI;
            pend_d = 1'b0;
          end else state_d = IDLE;
        end
      end
      GAP: begin
        if (p) begin
          pend_d = 1'b1;
          drop_d = pend_q;
        end
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (pend_q || p) begin
          state_d = HOLD;
          cnt_d   = HI;
          pend_d  = 1'b0;
        end else state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
    z_d    = state_d == HOLD;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
    end
  end
  assign z    = z_q;
  assign busy = busy_q;
  assign drop = drop_q;
endmodule
